// File: rtl/his_sched_pkg.sv
// Shared configuration, state encoding and derived widths for the histogram frame scheduler.
package his_sched_pkg;

    localparam int PIXEL_NUM  = 3;
    localparam int NP         = 10;
    localparam int ACQ_NUM    = 4;
    localparam int DATA_NUM   = 2;
    localparam int CLR_CYCLES = 4;
    localparam int PIPE_LAT   = 3;
    localparam int TIMEOUT    = 1024;

    localparam int SAMPLES_PER_PIX = ACQ_NUM * DATA_NUM;
    localparam int PIX_W           = $clog2(PIXEL_NUM);
    localparam int CNT_W           = $clog2(SAMPLES_PER_PIX + 1);
    localparam int CYC_W           = $clog2(TIMEOUT);

    function automatic int maxOf3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // One phase counter is shared by CLEAR, DRAIN and READOUT.
    localparam int PH_W = $clog2(maxOf3(CLR_CYCLES, PIPE_LAT, PIXEL_NUM));

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        COLLECT,
        DRAIN,
        READOUT,
        DONE
    } state_t;

endpackage

// File: rtl/his_frame_scheduler_if.sv
// Pixel, histogram-builder and readout signals of the frame scheduler.
interface his_frame_scheduler_if;
    import his_sched_pkg::*;

    logic [PIXEL_NUM-1:0]    pix_valid;
    logic [PIXEL_NUM*NP-1:0] pix_data;
    logic [PIXEL_NUM-1:0]    pix_ready;
    logic                    his_wrEn;
    logic [NP-1:0]           his_data;
    logic [PIX_W-1:0]        his_pix;
    logic                    his_clr;
    logic [PIXEL_NUM*NP-1:0] peak_in;
    logic                    peak_valid;
    logic [PIX_W-1:0]        peak_pix;
    logic [NP-1:0]           peak_data;

    modport master (
        input  pix_valid, pix_data, peak_in,
        output pix_ready, his_wrEn, his_data, his_pix, his_clr,
               peak_valid, peak_pix, peak_data
    );

    modport slave (
        output pix_valid, pix_data, peak_in,
        input  pix_ready, his_wrEn, his_data, his_pix, his_clr,
               peak_valid, peak_pix, peak_data
    );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin pick of the first requesting pixel at or after ptr, wrapping modulo PIXEL_NUM.
module rr_arbiter
    import his_sched_pkg::*;
(
    input  logic [PIXEL_NUM-1:0] req,
    input  logic [PIX_W-1:0]     ptr,
    output logic [PIXEL_NUM-1:0] grant,
    output logic [PIX_W-1:0]     grantIdx
);

    always_comb begin
        logic           found;
        logic [PIX_W:0] idx;
        grant    = '0;
        grantIdx = '0;
        found    = 1'b0;
        idx      = '0;
        for (int unsigned k = 0; k < PIXEL_NUM; k++) begin
            idx = {1'b0, ptr} + (PIX_W + 1)'(k);
            if (idx >= (PIX_W + 1)'(PIXEL_NUM)) begin
                idx = idx - (PIX_W + 1)'(PIXEL_NUM);
            end
            if (!found && req[idx[PIX_W-1:0]]) begin
                found                   = 1'b1;
                grant[idx[PIX_W-1:0]]   = 1'b1;
                grantIdx                = idx[PIX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/his_frame_scheduler.sv
// Frame controller: clears the histogram, arbitrates pixel timestamps onto the builder
// write port up to a per-pixel quota, then snapshots and serialises the peak results.
module his_frame_scheduler
    import his_sched_pkg::*;
(
    input  logic                  clk,
    input  logic                  res,
    input  logic                  start,
    his_frame_scheduler_if.master bus,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  timeout
);

    state_t               state, stateNext;
    logic [PH_W-1:0]      phaseCnt;
    logic [CYC_W-1:0]     cycCnt;
    logic [CNT_W-1:0]     sampleCnt [PIXEL_NUM];
    logic [PIX_W-1:0]     ptr;
    logic [NP-1:0]        snapshot  [PIXEL_NUM];
    logic [NP-1:0]        pixWord   [PIXEL_NUM];
    logic [PIXEL_NUM-1:0] eligible;
    logic [PIXEL_NUM-1:0] grant;
    logic [PIX_W-1:0]     grantIdx;
    logic                 xfer;
    logic                 quotaMet;
    logic                 cycLast;

    always_comb begin
        for (int unsigned i = 0; i < PIXEL_NUM; i++) begin
            pixWord[i]  = bus.pix_data[i*NP +: NP];
            eligible[i] = (state == COLLECT) && bus.pix_valid[i]
                          && (sampleCnt[i] != CNT_W'(SAMPLES_PER_PIX));
        end
    end

    rr_arbiter u_arb (
        .req      (eligible),
        .ptr      (ptr),
        .grant    (grant),
        .grantIdx (grantIdx)
    );

    assign xfer    = |(grant & bus.pix_valid);
    assign cycLast = (cycCnt == CYC_W'(TIMEOUT - 1));

    // Quota check includes this cycle's transfer, so a last sample on the final
    // COLLECT cycle completes the frame instead of timing out.
    always_comb begin
        quotaMet = 1'b1;
        for (int unsigned i = 0; i < PIXEL_NUM; i++) begin
            if ((sampleCnt[i] + CNT_W'(xfer && (grantIdx == PIX_W'(i))))
                    != CNT_W'(SAMPLES_PER_PIX)) begin
                quotaMet = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) state <= IDLE;
        else      state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        unique case (state)
            IDLE:    if (start) stateNext = CLEAR;
            CLEAR:   if (phaseCnt == PH_W'(CLR_CYCLES - 1)) stateNext = COLLECT;
            COLLECT: if (quotaMet || cycLast) stateNext = DRAIN;
            DRAIN:   if (phaseCnt == PH_W'(PIPE_LAT - 1)) stateNext = READOUT;
            READOUT: if (phaseCnt == PH_W'(PIXEL_NUM - 1)) stateNext = DONE;
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            phaseCnt     <= '0;
            cycCnt       <= '0;
            ptr          <= '0;
            timeout      <= 1'b0;
            bus.his_wrEn <= 1'b0;
            bus.his_data <= '0;
            bus.his_pix  <= '0;
            for (int unsigned i = 0; i < PIXEL_NUM; i++) begin
                sampleCnt[i] <= '0;
                snapshot[i]  <= '0;
            end
        end else begin
            phaseCnt     <= (stateNext != state) ? '0 : phaseCnt + 1'b1;
            bus.his_wrEn <= xfer;
            if (xfer) begin
                bus.his_data        <= pixWord[grantIdx];
                bus.his_pix         <= grantIdx;
                sampleCnt[grantIdx] <= sampleCnt[grantIdx] + 1'b1;
                ptr <= (grantIdx == PIX_W'(PIXEL_NUM - 1)) ? '0 : grantIdx + 1'b1;
            end
            if (state == IDLE && start) begin
                timeout <= 1'b0;
                cycCnt  <= '0;
                for (int unsigned i = 0; i < PIXEL_NUM; i++) sampleCnt[i] <= '0;
            end
            if (state == COLLECT) begin
                if (!cycLast) cycCnt <= cycCnt + 1'b1;
                if (cycLast && !quotaMet) timeout <= 1'b1;
            end
            if (state == DRAIN && stateNext == READOUT) begin
                for (int unsigned i = 0; i < PIXEL_NUM; i++) snapshot[i] <= bus.peak_in[i*NP +: NP];
            end
        end
    end

    always_comb begin
        busy           = (state != IDLE);
        frame_done     = (state == DONE);
        bus.his_clr    = (state == CLEAR);
        bus.pix_ready  = grant;
        bus.peak_valid = 1'b0;
        bus.peak_pix   = '0;
        bus.peak_data  = '0;
        if (state == READOUT) begin
            bus.peak_valid = 1'b1;
            bus.peak_pix   = PIX_W'(phaseCnt);
            bus.peak_data  = snapshot[phaseCnt];
        end
    end

endmodule

// File: tb/tb_his_frame_scheduler.sv
// Randomised frame-level bench for his_frame_scheduler with a quota/round-robin reference model.
module tb_his_frame_scheduler;
    import his_sched_pkg::*;

    logic clk = 1'b0;
    logic res = 1'b0;
    logic start = 1'b0;
    logic busy, frame_done, timeout;

    his_frame_scheduler_if bus();

    his_frame_scheduler dut (
        .clk        (clk),
        .res        (res),
        .start      (start),
        .bus        (bus),
        .busy       (busy),
        .frame_done (frame_done),
        .timeout    (timeout)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    int            mCnt     [PIXEL_NUM];
    int            wrSeen   [PIXEL_NUM];
    int            mPtr     = 0;
    bit            expWr    = 1'b0;
    int            expPix   = 0;
    int            expData  = 0;
    logic [NP-1:0] dataNow  [PIXEL_NUM];
    logic [NP-1:0] framePeak[PIXEL_NUM];

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic checkWrite(input string tag);
        checkEq({tag, "_wrEn"}, 32'(bus.his_wrEn), 32'(expWr));
        if (expWr) begin
            checkEq({tag, "_pix"}, 32'(bus.his_pix), expPix);
            checkEq({tag, "_data"}, 32'(bus.his_data), expData);
        end
        if (bus.his_wrEn === 1'b1 && bus.his_pix < PIXEL_NUM) wrSeen[bus.his_pix]++;
    endtask

    function automatic logic [PIXEL_NUM-1:0] patValid(input int mode, input int c);
        logic [PIXEL_NUM-1:0] v;
        v = '0;
        case (mode)
            0: v = '1;
            1: v[0] = 1'b1;
            2: begin
                v = '1;
                if (c % 3 != 0) v[1] = 1'b0;
            end
            3: if (c >= 1000) v = '1;
            default: v = PIXEL_NUM'($urandom_range(0, (1 << PIXEL_NUM) - 1));
        endcase
        return v;
    endfunction

    // mode: 0 all valid, 1 pixel 0 only (data 108), 2 pixel 1 every third cycle,
    // 3 traffic only from COLLECT cycle 1000, 4 random. abortAt >= 0 pulls reset mid-COLLECT.
    task automatic runFrame(input int mode, input int abortAt, input bit startInRo);
        logic [PIXEL_NUM-1:0] v;
        int  g;
        int  idx;
        int  c;
        bit  fin;
        bit  full;
        bit  expTo;
        expTo = 1'b0;
        for (int i = 0; i < PIXEL_NUM; i++) begin
            framePeak[i] = NP'($urandom_range(0, (1 << NP) - 1));
            bus.peak_in[i*NP +: NP] = framePeak[i];
            mCnt[i]   = 0;
            wrSeen[i] = 0;
        end
        expWr = 1'b0;
        bus.pix_valid = '1;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < CLR_CYCLES; k++) begin
            #1;
            checkEq("clr_high", 32'(bus.his_clr), 1);
            checkEq("clr_ready", 32'(bus.pix_ready), 0);
            checkEq("clr_busy", 32'(busy), 1);
            if (k == 0) checkEq("clr_timeout", 32'(timeout), 0);
            @(negedge clk);
        end
        fin = 1'b0;
        c = 0;
        while (!fin) begin
            v = patValid(mode, c);
            bus.pix_valid = v;
            for (int i = 0; i < PIXEL_NUM; i++) begin
                dataNow[i] = (mode == 1) ? NP'(108) : NP'($urandom_range(0, (1 << NP) - 1));
                bus.pix_data[i*NP +: NP] = dataNow[i];
            end
            #1;
            checkWrite("col");
            g = -1;
            for (int k = 0; k < PIXEL_NUM; k++) begin
                idx = (mPtr + k) % PIXEL_NUM;
                if (g < 0 && v[idx] && mCnt[idx] < SAMPLES_PER_PIX) g = idx;
            end
            checkEq("ready", 32'(bus.pix_ready), (g >= 0) ? (1 << g) : 0);
            if (g >= 0) begin
                mCnt[g]++;
                mPtr    = (g + 1) % PIXEL_NUM;
                expWr   = 1'b1;
                expPix  = g;
                expData = int'(dataNow[g]);
            end else begin
                expWr = 1'b0;
            end
            if (c == abortAt) begin
                #2;
                res = 1'b0;
                #1;
                checkEq("rst_busy", 32'(busy), 0);
                checkEq("rst_wrEn", 32'(bus.his_wrEn), 0);
                checkEq("rst_data", 32'(bus.his_data), 0);
                checkEq("rst_pix", 32'(bus.his_pix), 0);
                checkEq("rst_clr", 32'(bus.his_clr), 0);
                checkEq("rst_ready", 32'(bus.pix_ready), 0);
                checkEq("rst_pvalid", 32'(bus.peak_valid), 0);
                checkEq("rst_done", 32'(frame_done), 0);
                checkEq("rst_timeout", 32'(timeout), 0);
                mPtr  = 0;
                expWr = 1'b0;
                return;
            end
            full = 1'b1;
            for (int i = 0; i < PIXEL_NUM; i++) if (mCnt[i] != SAMPLES_PER_PIX) full = 1'b0;
            if (full) begin
                fin = 1'b1;
                expTo = 1'b0;
            end else if (c == TIMEOUT - 1) begin
                fin = 1'b1;
                expTo = 1'b1;
            end
            c++;
            @(negedge clk);
        end
        for (int k = 0; k < PIPE_LAT; k++) begin
            bus.pix_valid = '1;
            #1;
            checkWrite("drn");
            expWr = 1'b0;
            checkEq("drn_ready", 32'(bus.pix_ready), 0);
            checkEq("drn_pvalid", 32'(bus.peak_valid), 0);
            checkEq("drn_busy", 32'(busy), 1);
            @(negedge clk);
        end
        bus.pix_valid = '0;
        for (int k = 0; k < PIXEL_NUM; k++) begin
            #1;
            checkEq("ro_valid", 32'(bus.peak_valid), 1);
            checkEq("ro_pix", 32'(bus.peak_pix), k);
            checkEq("ro_data", 32'(bus.peak_data), 32'(framePeak[k]));
            checkEq("ro_wrEn", 32'(bus.his_wrEn), 0);
            if (k == 0) bus.peak_in = (PIXEL_NUM*NP)'({$urandom(), $urandom()});
            if (startInRo && k == 1) start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        #1;
        checkEq("done_pulse", 32'(frame_done), 1);
        checkEq("done_busy", 32'(busy), 1);
        checkEq("done_timeout", 32'(timeout), 32'(expTo));
        checkEq("done_pvalid", 32'(bus.peak_valid), 0);
        @(negedge clk);
        #1;
        checkEq("idle_done", 32'(frame_done), 0);
        checkEq("idle_busy", 32'(busy), 0);
        checkEq("idle_clr", 32'(bus.his_clr), 0);
        checkEq("idle_timeout", 32'(timeout), 32'(expTo));
        @(negedge clk);
        #1;
        checkEq("idle2_clr", 32'(bus.his_clr), 0);
        checkEq("idle2_busy", 32'(busy), 0);
        for (int i = 0; i < PIXEL_NUM; i++) checkEq("wr_count", wrSeen[i], mCnt[i]);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.pix_valid = '0;
        bus.pix_data  = '0;
        bus.peak_in   = '0;
        repeat (3) @(negedge clk);
        #1;
        checkEq("reset_busy", 32'(busy), 0);
        checkEq("reset_wrEn", 32'(bus.his_wrEn), 0);
        checkEq("reset_clr", 32'(bus.his_clr), 0);
        checkEq("reset_pvalid", 32'(bus.peak_valid), 0);
        checkEq("reset_timeout", 32'(timeout), 0);
        @(negedge clk);
        res = 1'b1;
        @(negedge clk);
        runFrame(0, 10, 1'b0);
        @(negedge clk);
        res = 1'b1;
        runFrame(0, -1, 1'b0);
        runFrame(1, -1, 1'b0);
        runFrame(3, -1, 1'b0);
        runFrame(2, -1, 1'b0);
        runFrame(4, -1, 1'b1);
        runFrame(4, -1, 1'b0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/his_frame_scheduler.md
Name: his_frame_scheduler

Overview:
Frame-level controller in front of hisBuilderFSM. It clears the histogram and round-robin arbitrates per-pixel TDC timestamps onto the builder's single write port, enforcing ACQ_NUM*DATA_NUM samples per pixel. After the builder pipeline drains, it snapshots the per-pixel peakResult vector and serialises it to the readout path.

Parameters:
PIXEL_NUM, 3, pixels sharing one histogram RAM (equals PIXEL_NUM_PER_RAM)
NP, 10, timestamp and peak width in bits
ACQ_NUM, 4, acquisitions per frame
DATA_NUM, 2, timestamps per pixel per acquisition
CLR_CYCLES, 4, cycles his_clr is held high
PIPE_LAT, 3, builder write-to-peak-stable latency in cycles
TIMEOUT, 1024, maximum number of COLLECT cycles

Ports:
clk  in  1  system clock, rising edge
res  in  1  asynchronous active-low reset
start  in  1  frame start pulse
pix_valid  in  PIXEL_NUM  per-pixel timestamp valid
pix_data  in  PIXEL_NUM*NP  packed timestamps; pixel i at [i*NP +: NP]
pix_ready  out  PIXEL_NUM  one-hot accept, combinational
his_wrEn  out  1  builder write enable, registered
his_data  out  NP  builder data, registered
his_pix  out  $clog2(PIXEL_NUM)  pixel index of his_data
his_clr  out  1  histogram clear
peak_in  in  PIXEL_NUM*NP  builder peakResult, packed
peak_valid  out  1  readout word valid
peak_pix  out  $clog2(PIXEL_NUM)  readout pixel index
peak_data  out  NP  readout peak bin
busy  out  1  high in any state other than IDLE
frame_done  out  1  one-cycle pulse at end of frame
timeout  out  1  sticky; set when COLLECT expired; cleared by next accepted start

Behaviour:
- Reset (res=0, async): state IDLE; all outputs 0; RR pointer 0; all counters 0.
- IDLE: start=1 -> CLEAR; clear timeout. start in any other state is ignored.
- CLEAR: his_clr=1 for exactly CLR_CYCLES cycles -> COLLECT. pix_ready=0.
- COLLECT:
  - A pixel is eligible when pix_valid[i]=1 and sample_cnt[i] < ACQ_NUM*DATA_NUM.
  - Round-robin grant: search starts at last_grant+1 mod PIXEL_NUM. At most one pix_ready bit is high per cycle, and only if that pixel is eligible.
  - Transfer = pix_valid[i] & pix_ready[i].
  - Cycle after a transfer: his_wrEn=1, his_data=pix_data[i], his_pix=i; sample_cnt[i]++. Otherwise his_wrEn=0 and his_data/his_pix hold their previous values.
  - Exit to DRAIN when all counters equal the quota. Also exit when the cycle counter reaches TIMEOUT-1; this sets timeout=1.
  - If the last sample and timeout occur in the same cycle, the frame counts as complete and timeout=0.
- DRAIN: wait PIPE_LAT cycles after the final his_wrEn, then latch peak_in into a snapshot register -> READOUT.
- READOUT: for k = 0..PIXEL_NUM-1 on consecutive cycles: peak_valid=1, peak_pix=k, peak_data=snapshot[k] -> DONE.
- DONE: frame_done=1 for one cycle -> IDLE.
- Counters: sample_cnt width $clog2(ACQ_NUM*DATA_NUM+1); cycle counter saturates and never wraps.
- Reset asserted mid-frame aborts immediately. No partial readout is produced after the reset is released.
- Pixels at quota are never granted again within the frame, even when valid.

Decomposition:
- Package his_sched_pkg:
  - state enum {IDLE, CLEAR, COLLECT, DRAIN, READOUT, DONE}
  - SAMPLES_PER_PIX = ACQ_NUM*DATA_NUM
  - PIX_W = $clog2(PIXEL_NUM)
  - counter width localparams
- Sub-module rr_arbiter:
  - inputs: req vector, pointer
  - outputs: one-hot grant, grant index

Test Plan:
- Reset: assert res=0 mid-COLLECT -> all outputs 0 immediately. Then res=1 with start=1 -> a fresh frame, with his_clr high for 4 cycles.
- All 3 pixels continuously valid -> grant order 0,1,2,0,1,2…; 24 consecutive his_wrEn with his_pix cycling 0,1,2; 3 DRAIN cycles; peak_pix 0,1,2 carrying peak_in slices; frame_done exactly once.
- Only pixel 0 valid, data=108 -> 8 writes of 108 with his_pix=0. Then no further grants, and timeout=1 after 1024 COLLECT cycles, followed by readout and frame_done.
- Pixel 1 valid only every 3rd cycle, pixels 0 and 2 continuous -> pixel 1 is never starved and still receives all 8 samples; all counters reach 8.
- Last sample accepted in COLLECT cycle 1023 -> timeout=0, and the normal DRAIN/READOUT sequence follows.
- start pulsed during READOUT -> ignored: one frame_done, no his_clr, and busy drops after DONE.
